// File: rtl/tpu_pkg.sv
// tpu_pkg: shared datapath width and sequencer state encoding for the TPU core.
package tpu_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DONE} seq_state_t;
endpackage

// File: rtl/input_skew.sv
// input_skew: triangular shift register delaying row i of the activation vector by i cycles.
module input_skew #(
  parameter int N      = 2,
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                clr,
  input  logic [N*DATA_W-1:0] din,
  output logic [N*DATA_W-1:0] dout
);
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i == 0) begin : g_pass
      assign dout[0 +: DATA_W] = din[0 +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] sr [i];
      always_ff @(posedge clk or posedge reset)
        if (reset)
          for (int k = 0; k < i; k++) sr[k] <= '0;
        else if (clr)
          for (int k = 0; k < i; k++) sr[k] <= '0;
        else if (shift_en) begin
          sr[0] <= din[i*DATA_W +: DATA_W];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      assign dout[i*DATA_W +: DATA_W] = sr[i-1];
    end
  end
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: loads weights, streams skewed activations and flags finished results for an N x N PE array.
module systolic_sequencer #(
  parameter  int N      = 2,
  parameter  int DATA_W = tpu_pkg::DATA_W,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          num_vecs,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       w_rd_addr,
  input  logic [N*DATA_W-1:0] w_rd_data,
  output logic [N*DATA_W-1:0] weight_out,
  output logic [N-1:0]        load_weight,
  output logic [7:0]          a_rd_addr,
  input  logic [N*DATA_W-1:0] a_rd_data,
  output logic [N*DATA_W-1:0] a_row,
  output logic                pe_valid,
  output logic [N-1:0]        result_valid
);
  import tpu_pkg::*;
  localparam int CW = $clog2(256 + 2*N);
  seq_state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] m;
  logic [N-1:0] rv_next;
  logic last_w, last_c, feed;
  assign last_w = cnt == CW'(N-1);
  assign last_c = cnt == CW'(m) + CW'(2*N-3);
  assign feed = state == COMPUTE && cnt < CW'(m);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign pe_valid = state == COMPUTE;
  assign w_rd_addr = state == LOAD_W ? cnt[AW-1:0] : '0;
  assign load_weight = state == LOAD_W ? N'(1) << cnt : '0;
  assign a_rd_addr = feed ? cnt[7:0] : '0;
  assign weight_out = w_rd_data;
  // Column j sees vector m at the bottom PE during step m+N-1+j.
  always_comb
    for (int j = 0; j < N; j++)
      rv_next[j] = cnt >= CW'(N-1+j) && cnt < CW'(N-1+j) + CW'(m);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      m <= '0;
      result_valid <= '0;
    end else begin
      result_valid <= state == COMPUTE ? rv_next : '0;
      case (state)
        IDLE:
          if (start) begin
            state <= LOAD_W;
            cnt <= '0;
            m <= num_vecs;
          end
        LOAD_W: begin
          cnt <= last_w ? '0 : cnt + 1'b1;
          if (last_w) state <= m == '0 ? DONE : COMPUTE;
        end
        COMPUTE: begin
          cnt <= last_c ? '0 : cnt + 1'b1;
          if (last_c) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  input_skew #(.N(N), .DATA_W(DATA_W)) u_skew (
    .clk(clk),
    .reset(reset),
    .shift_en(pe_valid),
    .clr(state == IDLE && start),
    .din(feed ? a_rd_data : '0),
    .dout(a_row)
  );
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed checks of the sequencer driving a behavioural 2x2 PE array, plus an N=4 long job.
module tb_systolic_sequencer;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  logic start = 0, busy, done, pe_valid;
  logic [7:0] nv = 0, a_rd_addr;
  logic [0:0] w_rd_addr;
  logic [15:0] w_rd_data, weight_out, a_rd_data, a_row;
  logic [1:0] load_weight, result_valid;
  logic [15:0] wmem [2];
  logic [15:0] amem [4];
  assign w_rd_data = wmem[w_rd_addr];
  assign a_rd_data = amem[a_rd_addr[1:0]];

  systolic_sequencer #(.N(2), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vecs(nv), .busy(busy), .done(done),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .weight_out(weight_out),
    .load_weight(load_weight), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .a_row(a_row), .pe_valid(pe_valid), .result_valid(result_valid)
  );

  logic start4 = 0, busy4, done4, pe_valid4;
  logic [7:0] nv4 = 8'd255, a_rd_addr4;
  logic [1:0] w_rd_addr4;
  logic [31:0] w_rd_data4 = 32'h0, weight_out4, a_rd_data4 = 32'h04030201, a_row4;
  logic [3:0] load_weight4, result_valid4;

  systolic_sequencer #(.N(4), .DATA_W(8)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .num_vecs(nv4), .busy(busy4), .done(done4),
    .w_rd_addr(w_rd_addr4), .w_rd_data(w_rd_data4), .weight_out(weight_out4),
    .load_weight(load_weight4), .a_rd_addr(a_rd_addr4), .a_rd_data(a_rd_data4),
    .a_row(a_row4), .pe_valid(pe_valid4), .result_valid(result_valid4)
  );

  // Weight-stationary PEs: activations move right, partial sums move down.
  logic [7:0] wt [2][2], ar [2][2], ps [2][2];
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        ar[i][j] <= 0;
        ps[i][j] <= 0;
      end
    end else
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
        if (load_weight[i]) wt[i][j] <= weight_out[j*8 +: 8];
        if (pe_valid) begin
          ar[i][j] <= j == 0 ? a_row[i*8 +: 8] : ar[i][j == 0 ? 0 : j-1];
          ps[i][j] <= (i == 0 ? 8'd0 : ps[i == 0 ? 0 : i-1][j])
                    + (j == 0 ? a_row[i*8 +: 8] : ar[i][j == 0 ? 0 : j-1]) * wt[i][j];
        end
      end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int lw_e [8] = '{1, 2, 0, 0, 0, 0, 0, 0};
  int pv_e [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int rv_e [8] = '{0, 0, 0, 0, 1, 3, 2, 0};
  int dn_e [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int bs_e [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  task automatic run_basic(input string tg);
    amem[0] = 16'h0101;
    amem[1] = 16'h0002;
    nv = 8'd2;
    start = 1;
    tick;
    start = 0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("%s lw c%0d", tg, c), 32'(load_weight), lw_e[c-1]);
      chk($sformatf("%s pv c%0d", tg, c), 32'(pe_valid), pv_e[c-1]);
      chk($sformatf("%s rv c%0d", tg, c), 32'(result_valid), rv_e[c-1]);
      chk($sformatf("%s done c%0d", tg, c), 32'(done), dn_e[c-1]);
      chk($sformatf("%s busy c%0d", tg, c), 32'(busy), bs_e[c-1]);
      if (c <= 2) chk($sformatf("%s waddr c%0d", tg, c), 32'(w_rd_addr), c - 1);
      if (c == 5) chk({tg, " col0 v0"}, 32'(ps[1][0]), 4);
      if (c == 6) chk({tg, " col0 v1"}, 32'(ps[1][0]), 2);
      if (c == 6) chk({tg, " col1 v0"}, 32'(ps[1][1]), 6);
      if (c == 7) chk({tg, " col1 v1"}, 32'(ps[1][1]), 4);
      tick;
    end
  endtask

  int first_rv, last_rv, done_c, done_n, c4;

  initial begin
    wmem[0] = 16'h0201;
    wmem[1] = 16'h0403;
    for (int k = 0; k < 4; k++) amem[k] = 16'h0;
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst lw", 32'(load_weight), 0);
    chk("rst pv", 32'(pe_valid), 0);
    chk("rst arow", 32'(a_row), 0);
    tick;
    tick;
    @(negedge clk);
    reset = 0;
    tick;

    run_basic("t1");

    amem[0] = 16'h0705;
    nv = 8'd1;
    start = 1;
    tick;
    start = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) chk("t2 arow s0", 32'(a_row), 32'h0005);
      if (c == 4) chk("t2 arow s1", 32'(a_row), 32'h0700);
      if (c == 5) chk("t2 arow s2", 32'(a_row), 32'h0000);
      if (c >= 3 && c <= 5) chk($sformatf("t2 araddr c%0d", c), 32'(a_rd_addr), 0);
      if (c == 5) chk("t2 rv c5", 32'(result_valid), 1);
      if (c == 5) chk("t2 col0", 32'(ps[1][0]), 26);
      if (c == 6) chk("t2 rv c6", 32'(result_valid), 2);
      if (c == 6) chk("t2 col1", 32'(ps[1][1]), 38);
      chk($sformatf("t2 done c%0d", c), 32'(done), c == 6 ? 1 : 0);
      tick;
    end
    chk("t2 idle", 32'(busy), 0);

    nv = 8'd0;
    start = 1;
    tick;
    start = 0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t3 lw c%0d", c), 32'(load_weight), c == 1 ? 1 : c == 2 ? 2 : 0);
      chk($sformatf("t3 done c%0d", c), 32'(done), c == 3 ? 1 : 0);
      chk($sformatf("t3 busy c%0d", c), 32'(busy), c <= 3 ? 1 : 0);
      chk($sformatf("t3 pv c%0d", c), 32'(pe_valid), 0);
      chk($sformatf("t3 rv c%0d", c), 32'(result_valid), 0);
      tick;
    end

    amem[0] = 16'h0101;
    nv = 8'd1;
    start = 1;
    tick;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 2) chk($sformatf("t4 lw c%0d", c), 32'(load_weight), c);
      if (c >= 3 && c <= 5) chk($sformatf("t4 pv c%0d", c), 32'(pe_valid), 1);
      if (c == 6) chk("t4 done", 32'(done), 1);
      if (c == 7) chk("t4 busy fall", 32'(busy), 0);
      if (c == 7) chk("t4 no lw in idle", 32'(load_weight), 0);
      if (c == 8) chk("t4 restart lw", 32'(load_weight), 1);
      tick;
    end
    start = 0;
    for (int k = 0; k < 20 && busy; k++) tick;
    chk("t4 drain", 32'(busy), 0);

    amem[0] = 16'h0101;
    amem[1] = 16'h0002;
    nv = 8'd2;
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    tick;
    chk("t5 pre pv", 32'(pe_valid), 1);
    chk("t5 pre arow", 32'(a_row), 32'h0102);
    #1 reset = 1;
    #1;
    chk("t5 busy", 32'(busy), 0);
    chk("t5 pv", 32'(pe_valid), 0);
    chk("t5 arow", 32'(a_row), 0);
    chk("t5 rv", 32'(result_valid), 0);
    chk("t5 lw", 32'(load_weight), 0);
    chk("t5 araddr", 32'(a_rd_addr), 0);
    chk("t5 waddr", 32'(w_rd_addr), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("t5 no done %0d", k), 32'(done), 0);
    end
    @(negedge clk);
    reset = 0;
    tick;
    chk("t5 idle after rst", 32'(busy), 0);
    run_basic("t5");

    first_rv = 0;
    last_rv = 0;
    done_c = 0;
    done_n = 0;
    start4 = 1;
    tick;
    start4 = 0;
    for (c4 = 1; c4 <= 300 && busy4; c4++) begin
      if (result_valid4[3]) begin
        if (first_rv == 0) first_rv = c4;
        last_rv = c4;
      end
      if (done4) begin
        done_c = c4;
        done_n++;
      end
      if (c4 == 5) chk("t6 arow s0", a_row4, 32'h00000001);
      if (c4 == 259) chk("t6 araddr s254", 32'(a_rd_addr4), 254);
      if (c4 == 260) chk("t6 araddr s255", 32'(a_rd_addr4), 0);
      if (c4 == 265) chk("t6 pv last", 32'(pe_valid4), 1);
      tick;
    end
    chk("t6 busy fall", c4, 267);
    chk("t6 done cycle", done_c, 266);
    chk("t6 done count", done_n, 1);
    chk("t6 rv3 first", first_rv, 12);
    chk("t6 rv3 last", last_rv, 266);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
